// File: rtl/vedic_seq_mul.sv
// ---------------------------------------------------------------------------
// vedic_mul_2x2 -- combinational 2-bit x 2-bit unsigned Vedic multiplier
// (vertical-and-crosswise), built from four ANDs and two half adders.
//   a, b : 2-bit operands
//   p    : 4-bit product
// ---------------------------------------------------------------------------
module vedic_mul_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_lo;
    logic cross_hi;
    logic top;
    logic c1;

    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign top      = a[1] & b[1];
    assign c1       = cross_lo & cross_hi;

    assign p = {top & c1, top ^ c1, cross_lo ^ cross_hi, a[0] & b[0]};
endmodule

// ---------------------------------------------------------------------------
// vedic_seq_mul -- sequential NxN unsigned multiplier that time-shares one
// vedic_mul_2x2 core over all D*D digit pairs of the latched operands.
// One digit pair is accumulated per RUN cycle; start-to-done is K = D*D edges.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request a multiply, honoured only in IDLE
//   a, b    : N-bit operands, latched on the edge that accepts start
//   busy    : high in RUN and DONE (registered)
//   done    : one-cycle pulse, product valid from this cycle (registered)
//   product : 2N-bit result, held until the next result is written
// ---------------------------------------------------------------------------
module vedic_seq_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int D  = N / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   busy_d, done_d;

    logic [N-1:0]   a_r, b_r;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  i, j;

    logic           last_j, last_step;
    logic [3:0]     pp;
    logic [CW+1:0]  shamt;
    logic [2*N-1:0] acc_sum;

    assign last_j    = (j == LAST);
    assign last_step = last_j && (i == LAST);

    // Digit pair i (of a) and j (of b) for the current step.
    vedic_mul_2x2 u_core (
        .a (a_r[{i, 1'b0} +: 2]),
        .b (b_r[{j, 1'b0} +: 2]),
        .p (pp)
    );

    // Partial-product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    assign shamt   = {({1'b0, i} + {1'b0, j}), 1'b0};
    assign acc_sum = acc + ((2 * N)'(pp) << shamt);

    // -- FSM: state register --------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    // busy/done are registered from the next-state decode so the outputs come
    // straight from flops with no path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // -- FSM: next-state logic ------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // -- FSM: output decode (feeds the output registers) ----------------------
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_next != IDLE) busy_d = 1'b1;
        if (state_next == DONE) done_d = 1'b1;
    end

    // -- Datapath ---------------------------------------------------------------
    // NOTE: operand, accumulator and counter registers are all reset so an
    // aborted multiply leaves no stale data behind; nothing here is a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (last_j) begin
                        j <= '0;
                        i <= i + CW'(1);
                    end else begin
                        j <= j + CW'(1);
                    end
                    if (last_step) begin
                        product <= acc_sum;
                        i       <= '0;
                        j       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
